demux1_3_stream: RTL and testbench

- 8-bit 1-to-3 demultiplexer with registered, handshaked outputs.
- Complements the existing 3:1 datapath mux (mux3_1): it steers one source word to one of three destination channels.
- Each channel has a one-entry output register with valid/ready flow control.
- Per-channel delivery counters and an invalid-select drop counter support debug and verification.

---
 rtl/demux1_3_stream_if.sv | 27 ++
 rtl/demux1_3_stream.sv | 90 +++++++++
 tb/tb_demux1_3_stream.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/demux1_3_stream_if.sv
// Stream bus for the 1:3 demultiplexer: source handshake, three output channels,
// and the debug counters.
interface demux1_3_stream_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] d;
   logic [1:0]       s;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y0, y1, y2;
   logic             v0, v1, v2;
   logic             r0, r1, r2;
   logic             err;
   logic [CNT_W-1:0] cnt0, cnt1, cnt2;
   logic [CNT_W-1:0] drop_cnt;

   modport slave (
      input  d, s, in_valid, r0, r1, r2,
      output in_ready, y0, y1, y2, v0, v1, v2, err, cnt0, cnt1, cnt2, drop_cnt
   );

   modport master (
      output d, s, in_valid, r0, r1, r2,
      input  in_ready, y0, y1, y2, v0, v1, v2, err, cnt0, cnt1, cnt2, drop_cnt
   );
endinterface

// File: rtl/demux1_3_stream.sv
// 1-to-3 stream demultiplexer: steers each accepted word into one of three
// one-entry output registers; s=3 words are dropped and flagged on err.
module demux1_3_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   demux1_3_stream_if.slave bus
);

   logic [WIDTH-1:0] y_q   [3];
   logic [CNT_W-1:0] cnt_q [3];
   logic [2:0]       v_q;
   logic [2:0]       r_vec;
   logic [2:0]       load;
   logic [2:0]       deliver;
   logic [CNT_W-1:0] drop_q;
   logic             err_q;
   logic             in_ready_c;
   logic             accept;
   logic             drop;

   assign r_vec   = {bus.r2, bus.r1, bus.r0};
   assign deliver = v_q & r_vec;

   // Selected register must be empty or draining now; invalid selects are always taken.
   always_comb begin
      in_ready_c = 1'b1;
      case (bus.s)
         2'd0:    in_ready_c = !v_q[0] | bus.r0;
         2'd1:    in_ready_c = !v_q[1] | bus.r1;
         2'd2:    in_ready_c = !v_q[2] | bus.r2;
         default: in_ready_c = 1'b1;
      endcase
   end

   assign accept = bus.in_valid & in_ready_c;
   assign drop   = accept & (bus.s == 2'd3);

   always_comb begin
      load    = '0;
      load[0] = accept & (bus.s == 2'd0);
      load[1] = accept & (bus.s == 2'd1);
      load[2] = accept & (bus.s == 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 3; k++) begin
            y_q[k]   <= '0;
            cnt_q[k] <= '0;
         end
         v_q    <= '0;
         drop_q <= '0;
         err_q  <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < 3; k++) begin
            // A load wins over a same-cycle drain so the channel stays full back-to-back.
            if (load[k]) begin
               y_q[k] <= bus.d;
               v_q[k] <= 1'b1;
            end else if (deliver[k]) begin
               v_q[k] <= 1'b0;
            end
            if (deliver[k]) begin
               cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
         end
         err_q <= drop;
         if (drop) begin
            drop_q <= drop_q + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.y0       = y_q[0];
   assign bus.y1       = y_q[1];
   assign bus.y2       = y_q[2];
   assign bus.v0       = v_q[0];
   assign bus.v1       = v_q[1];
   assign bus.v2       = v_q[2];
   assign bus.cnt0     = cnt_q[0];
   assign bus.cnt1     = cnt_q[1];
   assign bus.cnt2     = cnt_q[2];
   assign bus.drop_cnt = drop_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_demux1_3_stream.sv
// Bench for demux1_3_stream: directed vectors, a behavioural channel model
// checked every cycle, and literal expectations at key points.
module tb_demux1_3_stream;
   localparam int WIDTH = 8;
   localparam int CNT_W = 8;
   localparam int MOD   = 1 << CNT_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux1_3_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   demux1_3_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each channel is a slot that is either empty or holds one word.
   int m_y   [3];
   bit m_v   [3];
   int m_cnt [3];
   int m_drop;
   bit m_err;

   function automatic bit rsel(input int k);
      return (k == 0) ? bus.r0 : (k == 1) ? bus.r1 : bus.r2;
   endfunction

   function automatic bit m_ready();
      if (bus.s == 2'd3) return 1'b1;
      return !m_v[bus.s] || rsel(int'(bus.s));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit acc, del;
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            m_y[k] <= 0; m_v[k] <= 1'b0; m_cnt[k] <= 0;
         end
         m_drop <= 0;
         m_err  <= 1'b0;
      end else begin
         acc = bus.in_valid && m_ready();
         for (int k = 0; k < 3; k++) begin
            del = m_v[k] && rsel(k);
            if (del) m_cnt[k] <= (m_cnt[k] + 1) % MOD;
            if (acc && int'(bus.s) == k) begin
               m_y[k] <= int'(bus.d);
               m_v[k] <= 1'b1;
            end else if (del) begin
               m_v[k] <= 1'b0;
            end
         end
         m_err <= acc && bus.s == 2'd3;
         if (acc && bus.s == 2'd3) m_drop <= (m_drop + 1) % MOD;
      end
   end

   always @(negedge clk) begin
      check("m_y0", 32'(bus.y0), 32'(m_y[0]));
      check("m_y1", 32'(bus.y1), 32'(m_y[1]));
      check("m_y2", 32'(bus.y2), 32'(m_y[2]));
      check("m_v0", 32'(bus.v0), 32'(m_v[0]));
      check("m_v1", 32'(bus.v1), 32'(m_v[1]));
      check("m_v2", 32'(bus.v2), 32'(m_v[2]));
      check("m_cnt0", 32'(bus.cnt0), 32'(m_cnt[0]));
      check("m_cnt1", 32'(bus.cnt1), 32'(m_cnt[1]));
      check("m_cnt2", 32'(bus.cnt2), 32'(m_cnt[2]));
      check("m_drop", 32'(bus.drop_cnt), 32'(m_drop));
      check("m_err", 32'(bus.err), 32'(m_err));
      check("m_in_ready", 32'(bus.in_ready), 32'(m_ready()));
   end

   // Drive inputs just after a rising edge, then advance one cycle.
   task automatic step(input logic [WIDTH-1:0] d, input logic [1:0] s, input logic v);
      bus.d = d; bus.s = s; bus.in_valid = v;
      @(posedge clk); #1;
   endtask

   initial begin
      bus.d = '0; bus.s = '0; bus.in_valid = 1'b0;
      bus.r0 = 1'b1; bus.r1 = 1'b1; bus.r2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_y0", 32'(bus.y0), 32'h0);
      check("rst_v0", 32'(bus.v0), 32'h0);
      check("rst_cnt0", 32'(bus.cnt0), 32'h0);
      check("rst_drop", 32'(bus.drop_cnt), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);
      rst_n = 1'b1;

      // Reset asserted mid-run between edges clears a held word at once
      bus.r0 = 1'b0;
      step(8'h99, 2'd0, 1'b1);
      check("pre_rst_v0", 32'(bus.v0), 32'h1);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_v0", 32'(bus.v0), 32'h0);
      check("async_rst_y0", 32'(bus.y0), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.r0 = 1'b1;

      // Basic delivery
      step(8'h54, 2'd0, 1'b1);
      check("basic_y0", 32'(bus.y0), 32'h54);
      check("basic_v0", 32'(bus.v0), 32'h1);
      step(8'h63, 2'd1, 1'b1);
      step(8'h16, 2'd2, 1'b1);
      step(8'h00, 2'd0, 1'b0);
      check("basic_y0_hold", 32'(bus.y0), 32'h54);
      check("basic_y1", 32'(bus.y1), 32'h63);
      check("basic_y2", 32'(bus.y2), 32'h16);
      check("basic_cnt0", 32'(bus.cnt0), 32'h1);
      check("basic_cnt1", 32'(bus.cnt1), 32'h1);
      check("basic_cnt2", 32'(bus.cnt2), 32'h1);

      // Backpressure on channel 1
      bus.r1 = 1'b0;
      step(8'hA1, 2'd1, 1'b1);
      check("bp_v1", 32'(bus.v1), 32'h1);
      check("bp_y1", 32'(bus.y1), 32'hA1);
      bus.d = 8'hA2;
      #1;
      check("bp_in_ready_lo", 32'(bus.in_ready), 32'h0);
      @(posedge clk); #1;
      check("bp_y1_stable", 32'(bus.y1), 32'hA1);
      bus.r1 = 1'b1;
      #1;
      check("bp_in_ready_hi", 32'(bus.in_ready), 32'h1);
      @(posedge clk); #1;
      check("bp_y1_next", 32'(bus.y1), 32'hA2);
      check("bp_v1_next", 32'(bus.v1), 32'h1);
      check("bp_cnt1", 32'(bus.cnt1), 32'h2);
      step(8'h00, 2'd0, 1'b0);
      check("bp_cnt1_drain", 32'(bus.cnt1), 32'h3);

      // Stalled channel 2 does not block channels 0 and 1
      bus.r2 = 1'b0;
      step(8'h77, 2'd2, 1'b1);
      check("ind_v2", 32'(bus.v2), 32'h1);
      for (int i = 0; i < 4; i++) begin
         bus.d = WIDTH'(8'h10 + i); bus.s = 2'(i % 2); bus.in_valid = 1'b1;
         #1;
         check("ind_in_ready", 32'(bus.in_ready), 32'h1);
         @(posedge clk); #1;
      end
      step(8'h00, 2'd0, 1'b0);
      check("ind_cnt0", 32'(bus.cnt0), 32'h3);
      check("ind_cnt1", 32'(bus.cnt1), 32'h5);
      check("ind_y0", 32'(bus.y0), 32'h12);
      check("ind_y1", 32'(bus.y1), 32'h13);
      check("ind_y2", 32'(bus.y2), 32'h77);
      check("ind_v2_hold", 32'(bus.v2), 32'h1);

      // Invalid select twice back-to-back
      for (int i = 0; i < 2; i++) begin
         bus.d = 8'hFF; bus.s = 2'd3; bus.in_valid = 1'b1;
         #1;
         check("inv_in_ready", 32'(bus.in_ready), 32'h1);
         @(posedge clk); #1;
         check("inv_err_hi", 32'(bus.err), 32'h1);
      end
      step(8'h00, 2'd0, 1'b0);
      check("inv_err_lo", 32'(bus.err), 32'h0);
      check("inv_drop", 32'(bus.drop_cnt), 32'h2);
      check("inv_v0", 32'(bus.v0), 32'h0);
      check("inv_v1", 32'(bus.v1), 32'h0);
      check("inv_v2", 32'(bus.v2), 32'h1);
      bus.r2 = 1'b1;
      step(8'h00, 2'd0, 1'b0);

      // Counter wrap on channel 0 from a fresh reset
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) step(WIDTH'(i), 2'd0, 1'b1);
      check("wrap_cnt0_ff", 32'(bus.cnt0), 32'hFF);
      step(8'h00, 2'd0, 1'b0);
      check("wrap_cnt0_0", 32'(bus.cnt0), 32'h0);
      check("wrap_y0", 32'(bus.y0), 32'hFF);

      // Reset while channel 1 is stalled, then a normal load
      bus.r1 = 1'b0;
      step(8'h5A, 2'd1, 1'b1);
      check("midrst_v1_pre", 32'(bus.v1), 32'h1);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_v1", 32'(bus.v1), 32'h0);
      check("midrst_y1", 32'(bus.y1), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.r1 = 1'b1;
      step(8'h3C, 2'd1, 1'b1);
      check("midrst_load_v1", 32'(bus.v1), 32'h1);
      check("midrst_load_y1", 32'(bus.y1), 32'h3C);
      step(8'h00, 2'd0, 1'b0);
      check("midrst_cnt1", 32'(bus.cnt1), 32'h1);

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
